// File: rtl/aq_axi_sdma64_fifo_pkg.sv
// Shared definitions for the SDMA64 packet FIFO: write-side FSM encoding and
// pointer-width helper.
package aq_axi_sdma64_fifo_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_PKT     = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return depth + 1;
    endfunction

endpackage

// File: rtl/aq_axi_sdma64_sync_ram.sv
// Simple dual-port RAM, one clock, registered read. DEPTH is log2 of the
// entry count (address width).
module aq_axi_sdma64_sync_ram #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 65
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [DEPTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [DEPTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<DEPTH)-1];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/aq_axi_sdma64_pkt_fifo.sv
// Single-clock FWFT packet FIFO for the SDMA64 datapath.
//
// state      | meaning
// WR_IDLE    | between packets, nothing speculative written
// WR_PKT     | packet in progress, words stored but not yet committed
// WR_DISCARD | packet outgrew the FIFO, dropping words through its LAST
module aq_axi_sdma64_pkt_fifo
    import aq_axi_sdma64_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 10,
    parameter int FIFO_WIDTH = 64,
    parameter int PKT_MODE   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FIFO_WR_ENA,
    input  logic [FIFO_WIDTH-1:0] FIFO_WR_DATA,
    input  logic                  FIFO_WR_LAST,
    input  logic                  FIFO_WR_DROP,
    output logic                  FIFO_WR_FULL,
    output logic                  FIFO_WR_ALM_FULL,
    input  logic [FIFO_DEPTH-1:0] FIFO_WR_ALM_COUNT,
    output logic                  FIFO_WR_OVF,
    input  logic                  FIFO_RD_ENA,
    output logic [FIFO_WIDTH-1:0] FIFO_RD_DATA,
    output logic                  FIFO_RD_LAST,
    output logic                  FIFO_RD_EMPTY,
    output logic                  FIFO_RD_ALM_EMPTY,
    input  logic [FIFO_DEPTH-1:0] FIFO_RD_ALM_COUNT,
    output logic [FIFO_DEPTH:0]   FIFO_COUNT,
    output logic [FIFO_DEPTH:0]   FIFO_PKT_COUNT
);

    localparam int            PW      = ptr_width(FIFO_DEPTH);
    localparam logic [PW-1:0] CAP     = {1'b1, {FIFO_DEPTH{1'b0}}};
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]       wr_spec_q, wr_cmt_q, rd_q, fetch_q, pkt_q;
    logic [PW-1:0]       occ, count;
    logic [PW:0]         alm_sum;
    wr_state_e           state_q;
    logic                ovf_q, full, drop_en, wr_acc;
    logic                pop, issue, ram_vld_q;
    logic [1:0]          oc_q, stage_after, slot;
    logic [FIFO_WIDTH:0] stg0_q, stg1_q, stg0_d, stg1_d, ram_rd_data;

    assign occ     = wr_spec_q - rd_q;
    assign count   = wr_cmt_q - rd_q;
    assign full    = (occ == CAP);
    assign alm_sum = {1'b0, occ} + {2'b00, FIFO_WR_ALM_COUNT};
    assign drop_en = (PKT_MODE != 0) && FIFO_WR_DROP;
    assign wr_acc  = FIFO_WR_ENA && !full && !drop_en && (state_q != WR_DISCARD);

    assign FIFO_WR_FULL      = full;
    assign FIFO_WR_ALM_FULL  = (alm_sum >= {1'b0, CAP});
    assign FIFO_WR_OVF       = ovf_q;
    assign FIFO_COUNT        = count;
    assign FIFO_RD_ALM_EMPTY = (count <= {1'b0, FIFO_RD_ALM_COUNT});
    assign FIFO_PKT_COUNT    = pkt_q;

    // Write pointers, commit and the packet FSM; OVF is a registered pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_spec_q <= '0;
            wr_cmt_q  <= '0;
            state_q   <= WR_IDLE;
            ovf_q     <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (PKT_MODE == 0) begin
                if (wr_acc) begin
                    wr_spec_q <= wr_spec_q + PTR_ONE;
                    wr_cmt_q  <= wr_spec_q + PTR_ONE;
                end else if (FIFO_WR_ENA) begin
                    ovf_q <= 1'b1;
                end
            end else if (drop_en) begin
                wr_spec_q <= wr_cmt_q;
                if (state_q != WR_DISCARD || (FIFO_WR_ENA && FIFO_WR_LAST))
                    state_q <= WR_IDLE;
            end else if (state_q == WR_DISCARD) begin
                if (FIFO_WR_ENA) begin
                    ovf_q <= 1'b1;
                    if (FIFO_WR_LAST) state_q <= WR_IDLE;
                end
            end else if (FIFO_WR_ENA && full) begin
                ovf_q <= 1'b1;
                // A lone packet already fills every entry: it can never commit.
                if (state_q == WR_PKT && wr_cmt_q == rd_q) begin
                    wr_spec_q <= wr_cmt_q;
                    state_q   <= FIFO_WR_LAST ? WR_IDLE : WR_DISCARD;
                end
            end else if (wr_acc) begin
                wr_spec_q <= wr_spec_q + PTR_ONE;
                if (FIFO_WR_LAST) begin
                    wr_cmt_q <= wr_spec_q + PTR_ONE;
                    state_q  <= WR_IDLE;
                end else begin
                    state_q  <= WR_PKT;
                end
            end
        end
    end

    aq_axi_sdma64_sync_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_WIDTH + 1)
    ) u_ram (
        .clk_i     (CLK),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_spec_q[FIFO_DEPTH-1:0]),
        .wr_data_i ({FIFO_WR_LAST, FIFO_WR_DATA}),
        .rd_en_i   (issue),
        .rd_addr_i (fetch_q[FIFO_DEPTH-1:0]),
        .rd_data_o (ram_rd_data)
    );

    // Fetch only while the output stage plus the word in flight stays <= 2.
    assign pop         = FIFO_RD_ENA && (oc_q != 2'd0);
    assign stage_after = oc_q + {1'b0, ram_vld_q} - {1'b0, pop};
    assign issue       = (fetch_q != wr_cmt_q) && (stage_after < 2'd2);
    assign slot        = oc_q - {1'b0, pop};

    // Two-entry output stage: shift on pop, land the RAM word behind the head.
    always_comb begin
        stg0_d = stg0_q;
        stg1_d = stg1_q;
        if (pop) stg0_d = stg1_q;
        if (ram_vld_q) begin
            if (slot == 2'd0) stg0_d = ram_rd_data;
            else              stg1_d = ram_rd_data;
        end
    end

    // Read pointers, output stage and packet counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q      <= '0;
            fetch_q   <= '0;
            ram_vld_q <= 1'b0;
            oc_q      <= 2'd0;
            stg0_q    <= '0;
            stg1_q    <= '0;
            pkt_q     <= '0;
        end else begin
            ram_vld_q <= issue;
            oc_q      <= stage_after;
            stg0_q    <= stg0_d;
            stg1_q    <= stg1_d;
            if (issue) fetch_q <= fetch_q + PTR_ONE;
            if (pop)   rd_q    <= rd_q + PTR_ONE;
            case ({wr_acc && FIFO_WR_LAST, pop && stg0_q[FIFO_WIDTH]})
                2'b10:   pkt_q <= pkt_q + PTR_ONE;
                2'b01:   pkt_q <= pkt_q - PTR_ONE;
                default: pkt_q <= pkt_q;
            endcase
        end
    end

    assign FIFO_RD_DATA  = stg0_q[FIFO_WIDTH-1:0];
    assign FIFO_RD_LAST  = stg0_q[FIFO_WIDTH];
    assign FIFO_RD_EMPTY = (oc_q == 2'd0);

endmodule

// File: tb/tb_aq_axi_sdma64_pkt_fifo.sv
// Directed bench: instance a runs PKT_MODE=0, instance b PKT_MODE=1,
// both with 16 entries.
module tb_aq_axi_sdma64_pkt_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance a (PKT_MODE=0)
    logic        a_wr_ena, a_wr_last, a_wr_drop, a_full, a_alm_full, a_ovf;
    logic [63:0] a_wr_data, a_rd_data;
    logic        a_rd_ena, a_rd_last, a_empty, a_alm_empty;
    logic [3:0]  a_wr_alm, a_rd_alm;
    logic [4:0]  a_count, a_pkt;

    // Instance b (PKT_MODE=1)
    logic        b_wr_ena, b_wr_last, b_wr_drop, b_full, b_alm_full, b_ovf;
    logic [63:0] b_wr_data, b_rd_data;
    logic        b_rd_ena, b_rd_last, b_empty, b_alm_empty;
    logic [3:0]  b_wr_alm, b_rd_alm;
    logic [4:0]  b_count, b_pkt;

    aq_axi_sdma64_pkt_fifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(64), .PKT_MODE(0)) u_dut_a (
        .CLK(clk), .RST(rst),
        .FIFO_WR_ENA(a_wr_ena), .FIFO_WR_DATA(a_wr_data), .FIFO_WR_LAST(a_wr_last),
        .FIFO_WR_DROP(a_wr_drop), .FIFO_WR_FULL(a_full), .FIFO_WR_ALM_FULL(a_alm_full),
        .FIFO_WR_ALM_COUNT(a_wr_alm), .FIFO_WR_OVF(a_ovf),
        .FIFO_RD_ENA(a_rd_ena), .FIFO_RD_DATA(a_rd_data), .FIFO_RD_LAST(a_rd_last),
        .FIFO_RD_EMPTY(a_empty), .FIFO_RD_ALM_EMPTY(a_alm_empty),
        .FIFO_RD_ALM_COUNT(a_rd_alm), .FIFO_COUNT(a_count), .FIFO_PKT_COUNT(a_pkt)
    );

    aq_axi_sdma64_pkt_fifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(64), .PKT_MODE(1)) u_dut_b (
        .CLK(clk), .RST(rst),
        .FIFO_WR_ENA(b_wr_ena), .FIFO_WR_DATA(b_wr_data), .FIFO_WR_LAST(b_wr_last),
        .FIFO_WR_DROP(b_wr_drop), .FIFO_WR_FULL(b_full), .FIFO_WR_ALM_FULL(b_alm_full),
        .FIFO_WR_ALM_COUNT(b_wr_alm), .FIFO_WR_OVF(b_ovf),
        .FIFO_RD_ENA(b_rd_ena), .FIFO_RD_DATA(b_rd_data), .FIFO_RD_LAST(b_rd_last),
        .FIFO_RD_EMPTY(b_empty), .FIFO_RD_ALM_EMPTY(b_alm_empty),
        .FIFO_RD_ALM_COUNT(b_rd_alm), .FIFO_COUNT(b_count), .FIFO_PKT_COUNT(b_pkt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_write(input logic [63:0] d, input logic last);
        b_wr_ena  = 1'b1;
        b_wr_data = d;
        b_wr_last = last;
        tick();
        b_wr_ena  = 1'b0;
        b_wr_last = 1'b0;
    endtask

    task automatic b_read(input string tag, input logic [63:0] d, input logic last);
        chk({tag, "_empty"}, b_empty, 1'b0);
        chk({tag, "_data"}, b_rd_data, d);
        chk({tag, "_last"}, b_rd_last, last);
        b_rd_ena = 1'b1;
        tick();
        b_rd_ena = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_wr_ena = 0; a_wr_last = 0; a_wr_drop = 0; a_wr_data = '0; a_rd_ena = 0;
        b_wr_ena = 0; b_wr_last = 0; b_wr_drop = 0; b_wr_data = '0; b_rd_ena = 0;
        a_wr_alm = 4'd3; a_rd_alm = 4'd2;
        b_wr_alm = 4'd3; b_rd_alm = 4'd2;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_full", a_full, 1'b0);
        chk("rst_alm_full", a_alm_full, 1'b0);
        chk("rst_ovf", a_ovf, 1'b0);
        chk("rst_empty", a_empty, 1'b1);
        chk("rst_alm_empty", a_alm_empty, 1'b1);
        chk("rst_count", a_count, 5'd0);
        chk("rst_pkt", a_pkt, 5'd0);
        chk("rst_data", a_rd_data, 64'd0);
        chk("rst_last", a_rd_last, 1'b0);

        // Mode 0: fill 16 words, latency, almost-full, full
        for (int i = 0; i < 16; i++) begin
            a_wr_ena  = 1'b1;
            a_wr_data = 64'(i);
            tick();
            if (i == 1)  chk("a_lat_empty1", a_empty, 1'b1);
            if (i == 2)  begin
                chk("a_lat_empty2", a_empty, 1'b0);
                chk("a_lat_data", a_rd_data, 64'd0);
            end
            if (i == 11) chk("a_alm_full12", a_alm_full, 1'b0);
            if (i == 12) chk("a_alm_full13", a_alm_full, 1'b1);
            if (i == 14) chk("a_full15", a_full, 1'b0);
        end
        chk("a_full16", a_full, 1'b1);
        chk("a_count16", a_count, 5'd16);
        a_wr_data = 64'h99;
        tick();
        chk("a_ovf", a_ovf, 1'b1);
        chk("a_count_ovf", a_count, 5'd16);
        a_wr_ena = 1'b0;
        tick();
        chk("a_ovf_clr", a_ovf, 1'b0);

        // Mode 0: drain in order at one word per cycle
        for (int i = 0; i < 16; i++) begin
            chk("a_rd_empty", a_empty, 1'b0);
            chk("a_rd_data", a_rd_data, 64'(i));
            chk("a_rd_count", a_count, 64'(16 - i));
            chk("a_rd_alm_empty", a_alm_empty, (16 - i) <= 2);
            a_rd_ena = 1'b1;
            tick();
        end
        chk("a_drained_empty", a_empty, 1'b1);
        chk("a_drained_count", a_count, 5'd0);
        tick();
        chk("a_rd_on_empty_count", a_count, 5'd0);
        a_rd_ena = 1'b0;

        // Mode 0: pop and commit together at COUNT=5
        for (int i = 0; i < 5; i++) begin
            a_wr_ena  = 1'b1;
            a_wr_data = 64'h20 + 64'(i);
            tick();
        end
        a_wr_ena = 1'b0;
        tick(); tick(); tick();
        chk("a_cnt5", a_count, 5'd5);
        a_wr_ena  = 1'b1;
        a_wr_data = 64'h25;
        a_rd_ena  = 1'b1;
        tick();
        a_wr_ena  = 1'b0;
        a_rd_ena  = 1'b0;
        chk("a_popcmt_count", a_count, 5'd5);
        for (int k = 1; k <= 5; k++) begin
            chk("a_popcmt_data", a_rd_data, 64'h20 + 64'(k));
            a_rd_ena = 1'b1;
            tick();
        end
        a_rd_ena = 1'b0;
        chk("a_popcmt_empty", a_empty, 1'b1);

        // Mode 1: 3-word packet becomes visible only after LAST
        b_write(64'hA0, 1'b0);
        chk("b_p1_empty_w1", b_empty, 1'b1);
        b_write(64'hA1, 1'b0);
        chk("b_p1_count_w2", b_count, 5'd0);
        b_write(64'hA2, 1'b1);
        chk("b_p1_pkt", b_pkt, 5'd1);
        chk("b_p1_count", b_count, 5'd3);
        chk("b_p1_empty_t", b_empty, 1'b1);
        tick();
        chk("b_p1_empty_t1", b_empty, 1'b1);
        tick();
        b_read("b_p1_w0", 64'hA0, 1'b0);
        b_read("b_p1_w1", 64'hA1, 1'b0);
        chk("b_p1_pkt_before", b_pkt, 5'd1);
        b_read("b_p1_w2", 64'hA2, 1'b1);
        chk("b_p1_pkt_after", b_pkt, 5'd0);
        chk("b_p1_empty_end", b_empty, 1'b1);

        // Mode 1: drop with the third word, then a clean packet
        b_write(64'hB0, 1'b0);
        b_write(64'hB1, 1'b0);
        b_wr_drop = 1'b1;
        b_write(64'hB2, 1'b0);
        b_wr_drop = 1'b0;
        chk("b_drop_ovf", b_ovf, 1'b0);
        chk("b_drop_count", b_count, 5'd0);
        chk("b_drop_empty", b_empty, 1'b1);
        tick(); tick();
        chk("b_drop_empty2", b_empty, 1'b1);
        b_write(64'hC0, 1'b0);
        b_write(64'hC1, 1'b1);
        tick(); tick();
        b_read("b_p2_w0", 64'hC0, 1'b0);
        b_read("b_p2_w1", 64'hC1, 1'b1);
        chk("b_p2_pkt", b_pkt, 5'd0);

        // Mode 1: oversize packet is discarded through its LAST
        for (int i = 0; i < 20; i++) begin
            b_write(64'h100 + 64'(i), i == 19);
            if (i == 15) begin
                chk("b_big_full", b_full, 1'b1);
                chk("b_big_noovf", b_ovf, 1'b0);
            end
            if (i == 16) chk("b_big_ovf", b_ovf, 1'b1);
        end
        tick();
        chk("b_big_count", b_count, 5'd0);
        chk("b_big_empty", b_empty, 1'b1);
        chk("b_big_full_clr", b_full, 1'b0);
        chk("b_big_pkt", b_pkt, 5'd0);
        for (int i = 0; i < 4; i++) b_write(64'h200 + 64'(i), i == 3);
        tick(); tick();
        for (int i = 0; i < 4; i++) b_read("b_p3", 64'h200 + 64'(i), i == 3);

        // Mode 1: reset mid-packet with 6 committed words
        for (int i = 0; i < 6; i++) b_write(64'h400 + 64'(i), i == 5);
        b_write(64'h500, 1'b0);
        b_write(64'h501, 1'b0);
        tick();
        chk("b_pre_rst_count", b_count, 5'd6);
        chk("b_pre_rst_data", b_rd_data, 64'h400);
        rst      = 1'b1;
        b_wr_ena = 1'b1;
        b_wr_data = 64'h502;
        tick();
        rst      = 1'b0;
        b_wr_ena = 1'b0;
        chk("b_rst_full", b_full, 1'b0);
        chk("b_rst_alm_full", b_alm_full, 1'b0);
        chk("b_rst_ovf", b_ovf, 1'b0);
        chk("b_rst_empty", b_empty, 1'b1);
        chk("b_rst_alm_empty", b_alm_empty, 1'b1);
        chk("b_rst_count", b_count, 5'd0);
        chk("b_rst_pkt", b_pkt, 5'd0);
        chk("b_rst_data", b_rd_data, 64'd0);
        chk("b_rst_last", b_rd_last, 1'b0);
        b_write(64'h300, 1'b0);
        b_write(64'h301, 1'b1);
        chk("b_post_rst_count", b_count, 5'd2);
        tick(); tick();
        b_read("b_post_w0", 64'h300, 1'b0);
        b_read("b_post_w1", 64'h301, 1'b1);
        chk("b_post_empty", b_empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aq_axi_sdma64_pkt_fifo.md
Name: aq_axi_sdma64_pkt_fifo

Overview:
- Single-clock, first-word-fall-through FIFO for the SDMA64 datapath; next generation of the DMA staging FIFO.
- Adds packet awareness: LAST stored per word, optional store-and-forward commit, write-side packet drop, oversize-packet auto-discard, occupancy and packet counters.
- Sits between the AXI read-data channel and the stream output, or between the stream input and AXI write-data, in single-clock builds.

Parameters:
FIFO_DEPTH, 10, log2 of entry count; storage is 2**FIFO_DEPTH words.
FIFO_WIDTH, 64, data width in bits.
PKT_MODE, 1, 0 = every accepted word is committed at once; 1 = words become readable only when their packet's LAST is accepted.

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  reset, synchronous, active-high.
FIFO_WR_ENA  in  1  write request.
FIFO_WR_DATA  in  FIFO_WIDTH  write data.
FIFO_WR_LAST  in  1  last word of packet.
FIFO_WR_DROP  in  1  discard the current uncommitted packet.
FIFO_WR_FULL  out  1  no free entry.
FIFO_WR_ALM_FULL  out  1  occupancy + FIFO_WR_ALM_COUNT >= 2**FIFO_DEPTH.
FIFO_WR_ALM_COUNT  in  FIFO_DEPTH  almost-full margin.
FIFO_WR_OVF  out  1  one-cycle pulse on a rejected or auto-discarded write.
FIFO_RD_ENA  in  1  pop head word.
FIFO_RD_DATA  out  FIFO_WIDTH  head data, valid when EMPTY=0.
FIFO_RD_LAST  out  1  head LAST flag.
FIFO_RD_EMPTY  out  1  no readable word at head.
FIFO_RD_ALM_EMPTY  out  1  FIFO_COUNT <= FIFO_RD_ALM_COUNT.
FIFO_RD_ALM_COUNT  in  FIFO_DEPTH  almost-empty threshold.
FIFO_COUNT  out  FIFO_DEPTH+1  committed, unpopped words, including the output stage.
FIFO_PKT_COUNT  out  FIFO_DEPTH+1  complete packets committed and not fully popped.

Behaviour:
Pointers and occupancy
- Pointers are FIFO_DEPTH+1 bits: wr_spec (speculative write), wr_cmt (committed), rd (popped). All arithmetic is modulo 2**(FIFO_DEPTH+1).
- Physical occupancy = wr_spec - rd. FULL = (occupancy == 2**FIFO_DEPTH). FULL and ALM_FULL are derived from registered pointers.
- FIFO_COUNT = wr_cmt - rd.

Write acceptance and commit
- A write is accepted when FIFO_WR_ENA=1, FULL=0, FIFO_WR_DROP=0 and the FSM is not in DISCARD.
- Accepted data and LAST go to RAM[wr_spec], and wr_spec increments.
- PKT_MODE=0: wr_cmt follows wr_spec every cycle; DROP is ignored.
- PKT_MODE=1: wr_cmt <= wr_spec+1 on an accepted LAST word.

Drop
- FIFO_WR_DROP=1 (PKT_MODE=1) sets wr_spec <= wr_cmt.
- DROP and ENA in the same cycle: DROP wins and the word is discarded without an OVF pulse.

Write FSM (PKT_MODE=1)
- IDLE -> PKT on an accepted non-LAST word.
- PKT -> IDLE on an accepted LAST word or on DROP.
- PKT -> DISCARD when ENA=1, FULL=1 and wr_cmt == rd (a single packet fills the FIFO). Action: wr_spec <= wr_cmt, OVF pulse.
- DISCARD: every ENA word is discarded; returns to IDLE on the cycle after ENA & LAST.
- Any other write while FULL: the word is ignored, OVF pulses, and the state is unchanged.

Read side
- Simple dual-port RAM with 1-cycle registered read, plus a 2-entry prefetch/output stage.
- Latency: with the output stage empty, a word committed at edge t is presented with EMPTY=0 after edge t+2.
- FIFO_RD_ENA with EMPTY=0 pops the head. If a further committed word exists, the next word is presented the following cycle, giving sustained 1 word/cycle.
- FIFO_RD_ENA with EMPTY=1 is ignored.
- Pop and commit in the same cycle are both applied.

Packet counter
- FIFO_PKT_COUNT +1 on a committed LAST word, -1 on a popped LAST word; both in the same cycle leave it unchanged.
- In PKT_MODE=0, only words with LAST count.

Reset
- Pointers 0, FSM IDLE, output stage empty.
- Outputs: FULL=0, ALM_FULL=0, OVF=0, EMPTY=1, ALM_EMPTY=1, COUNT=0, PKT_COUNT=0, RD_DATA=0, RD_LAST=0.
- Reset mid-packet discards everything, committed data included.

Decomposition:
- Shared package/header aq_axi_sdma64_fifo_pkg: write-FSM state encoding (IDLE, PKT, DISCARD) and the pointer-width constant/function.
- One sub-module: aq_axi_sdma64_sync_ram (parameters DEPTH, WIDTH; single clock; registered read). Instantiated with WIDTH=FIFO_WIDTH+1 to store LAST.

Test Plan:
- PKT_MODE=0, FIFO_DEPTH=4: write 0x0..0xF back-to-back -> FULL after the 16th write; a 17th write gives an OVF pulse; reads return 0x0..0xF in order; EMPTY=0 two edges after the first write.
- PKT_MODE=1: write 3 words, LAST on the 3rd -> EMPTY stays 1 until the LAST edge +2; PKT_COUNT=1; reads give RD_LAST=1 on the 3rd word, then PKT_COUNT=0.
- PKT_MODE=1: 2 words, then DROP asserted together with ENA on the 3rd -> COUNT=0, EMPTY=1, no OVF; the next 2-word packet reads back intact.
- FIFO_DEPTH=4, PKT_MODE=1: a 20-word packet -> OVF on the 17th word; the FSM discards through LAST; FIFO empty; a following 4-word packet is read correctly.
- Simultaneous pop and commit at COUNT=5 -> COUNT stays 5. WR_ALM_COUNT=3 -> ALM_FULL asserts at occupancy 13. RD_ALM_COUNT=2 -> ALM_EMPTY=1 at COUNT<=2.
- Assert RST mid-packet with 6 committed words -> the next cycle shows reset values on all outputs; subsequent traffic starts from address 0.
